// File: rtl/sram_in_stream_reader.sv
// sram_in_stream_reader
//   Read-side initiator for the 128-word input SRAM feeding the systolic
//   array. A start command launches sequential reads from base_addr
//   (wrapping modulo DEPTH). Returned words land in a small buffer that is
//   drained through a valid/ready stream. Reads are issued only against
//   free buffer credits, so returning data always has a slot.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   start, base_addr,   command pulse with first address and word count
//   len                 (0..DEPTH); sampled only while busy=0
//   busy, done          transfer in progress / one-cycle completion pulse
//   sram_*0             SRAM read port (csb/addr registered, write side tied off)
//   out_valid/ready     output stream handshake
//   out_data/spare/last word payload, spare bit, final-word marker
//   dbg_state           current FSM state (0 idle, 1 run, 2 drain)
//
// Stream handshake: a word transfers on a cycle where out_valid && out_ready.
// While out_valid=1 and out_ready=0 the payload (out_data, out_spare,
// out_last) is held stable; out_valid never drops without a transfer.
module sram_in_stream_reader #(
    parameter int DATA_WIDTH = 33,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic                  sram_spare_wen0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-2:0] out_data,
    output logic                  out_spare,
    output logic                  out_last,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = FW + 2;

    state_t                state;
    logic [ADDR_WIDTH-2:0] cur_addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic                  rd_last;
    logic                  cap_v;
    logic                  cap_last;
    logic                  zero_done;

    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [FW-1:0]         fifo_cnt;
    logic [DATA_WIDTH:0]   head;

    logic                  rd_v;
    logic                  pop;
    logic                  issue;
    logic [CW-1:0]         outstanding;

    assign sram_web0       = 1'b1;
    assign sram_spare_wen0 = 1'b0;
    assign sram_din0       = '0;

    // A read is in flight during the cycle its chip select is low.
    assign rd_v = ~sram_csb0;

    assign head      = fifo_mem[rd_ptr];
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = head[DATA_WIDTH-2:0];
    assign out_spare = head[DATA_WIDTH-1];
    assign out_last  = out_valid & head[DATA_WIDTH];
    assign pop       = out_valid & out_ready;

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;
    assign done      = zero_done | ((state == S_DRAIN) & pop & out_last);

    // Credits: words held (net of this cycle's pop) plus reads still on the
    // way back (one on the SRAM port, one captured and about to be pushed).
    always_comb begin
        outstanding = CW'(fifo_cnt) + CW'(cap_v) + CW'(rd_v) - CW'(pop);
        issue       = (state == S_RUN) && (remaining != '0) &&
                      (outstanding < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            sram_csb0  <= 1'b1;
            sram_addr0 <= '0;
            rd_last    <= 1'b0;
            cap_v      <= 1'b0;
            cap_last   <= 1'b0;
            zero_done  <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            sram_csb0 <= ~issue;
            // Data for the read on the port now appears next cycle and is
            // pushed into the buffer on the edge after that.
            cap_v     <= rd_v;
            cap_last  <= rd_last;

            if (issue) begin
                sram_addr0 <= {1'b0, cur_addr};
                rd_last    <= (remaining == ADDR_WIDTH'(1));
                remaining  <= remaining - ADDR_WIDTH'(1);
                if (cur_addr == (ADDR_WIDTH-1)'(DEPTH - 1))
                    cur_addr <= '0;
                else
                    cur_addr <= cur_addr + (ADDR_WIDTH-1)'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            cur_addr  <= base_addr;
                            remaining <= len;
                            state     <= S_RUN;
                        end else begin
                            zero_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue && (remaining == ADDR_WIDTH'(1)))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && out_last)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (cap_v) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({cap_v, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible after it was pushed.
    always_ff @(posedge clk) begin
        if (cap_v) fifo_mem[wr_ptr] <= {cap_last, sram_dout0};
    end

endmodule

// File: tb/tb_sram_in_stream_reader.sv
module tb_sram_in_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  base_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done;
    logic        sram_csb0, sram_web0, sram_spare_wen0;
    logic [7:0]  sram_addr0;
    logic [32:0] sram_din0;
    logic [32:0] sram_dout0 = 33'h0_dead_beef;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_spare, out_last;
    logic [1:0]  dbg_state;

    sram_in_stream_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_spare_wen0(sram_spare_wen0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_spare(out_spare),
        .out_last(out_last), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // SRAM model: captures the read on the edge after csb0 goes low, drives
    // the word for one cycle, then a poison value.
    logic [32:0] mem [128];
    always @(posedge clk) begin
        if (!sram_csb0) sram_dout0 <= mem[sram_addr0[6:0]];
        else            sram_dout0 <= 33'h0_dead_beef;
    end

    // scoreboard state
    logic [33:0] exp_q [$];     // {last, spare, data}
    logic [6:0]  addr_q [$];
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int starts_pushed = 0;
    int lasts_popped = 0;
    int flushed = 0;
    int zero_req = 0;
    int zero_ack = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit model_busy();
        return starts_pushed != (lasts_popped + flushed);
    endfunction

    // driver: issue a command; the reference model expands it into the
    // expected address sequence and word stream unless a transfer is active.
    task automatic do_start(input logic [6:0] b, input int l);
        bit accepted;
        @(posedge clk); #1;
        base_addr = b;
        len = 8'(l);
        start = 1'b1;
        accepted = !model_busy();
        if (accepted && l > 0) begin
            for (int i = 0; i < l; i++) begin
                logic [6:0] a;
                a = 7'((int'(b) + i) % 128);
                addr_q.push_back(a);
                exp_q.push_back({(i == l - 1) ? 1'b1 : 1'b0, mem[a]});
            end
            starts_pushed++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (accepted && l == 0) zero_req++;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            if (exp_q.size() == 0 && addr_q.size() == 0 && !busy && zero_req == zero_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", ok, 1);
        out_ready = 1'b1;
    endtask

    // monitor: reads and stream words are compared against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            logic        done_exp;
            logic [33:0] e;
            done_exp = (zero_req != zero_ack);
            zero_ack = zero_req;
            if (!sram_csb0) begin
                rd_cnt++;
                if (addr_q.size() == 0) check("unexpected_read", {56'd0, sram_addr0}, 64'hffff);
                else check("rd_addr", sram_addr0, {1'b0, addr_q.pop_front()});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {out_last, out_spare, out_data}, 64'hffff_ffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {out_last, out_spare, out_data}, e);
                    if (e[33]) begin
                        done_exp = 1'b1;
                        lasts_popped++;
                    end
                end
            end
            check("done", done, done_exp);
        end
    end

    initial begin
        int r0;
        for (int i = 0; i < 128; i++) mem[i] = {(i % 5 == 0) ? 1'b1 : 1'b0, 32'(i)};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_csb", sram_csb0, 1);
        check("rst_addr", sram_addr0, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("tie_web", sram_web0, 1);
        check("tie_spare_wen", sram_spare_wen0, 0);
        check("tie_din", sram_din0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic: first valid three cycles after start, four back-to-back words
        do_start(7'd0, 4);
        check("busy_after_start", busy, 1);
        @(posedge clk); #1; check("valid_c1", out_valid, 0);
        @(posedge clk); #1; check("valid_c2", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; check("valid_burst", out_valid, 1);
        end
        @(posedge clk); #1; check("valid_after", out_valid, 0);
        wait_idle(50, 1'b0);
        check("busy_end", busy, 0);

        // wrap
        do_start(7'd126, 4);
        wait_idle(50, 1'b0);

        // backpressure: only FIFO_DEPTH reads issued while stalled
        out_ready = 1'b0;
        r0 = rd_cnt;
        do_start(7'd10, 10);
        repeat (20) @(posedge clk);
        #1;
        check("stall_reads", rd_cnt - r0, 4);
        check("stall_csb", sram_csb0, 1);
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, 10);
        check("stall_spare", out_spare, 1);
        out_ready = 1'b1;
        wait_idle(60, 1'b0);
        check("stall_total_reads", rd_cnt - r0, 10);

        // len=0
        r0 = rd_cnt;
        do_start(7'd33, 0);
        check("zero_busy", busy, 0);
        wait_idle(10, 1'b0);
        check("zero_reads", rd_cnt - r0, 0);

        // start during a transfer is ignored
        do_start(7'd20, 6);
        do_start(7'd90, 3);
        wait_idle(60, 1'b0);

        // full memory
        r0 = rd_cnt;
        do_start(7'(($urandom_range(0, 127))), 128);
        wait_idle(400, 1'b0);
        check("full_reads", rd_cnt - r0, 128);

        // random contents, commands and backpressure
        for (int i = 0; i < 128; i++) mem[i] = {1'($urandom_range(0, 1)), $urandom};
        for (int t = 0; t < 15; t++) begin
            do_start(7'($urandom_range(0, 127)), int'($urandom_range(0, 20)));
            wait_idle(300, 1'b1);
        end

        // reset mid-transfer
        do_start(7'd40, 30);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_csb", sram_csb0, 1);
        check("mid_rst_addr", sram_addr0, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_last", out_last, 0);
        exp_q.delete();
        addr_q.delete();
        flushed = starts_pushed - lasts_popped;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_start(7'd5, 2);
        wait_idle(50, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_in_stream_reader.md
Name: sram_in_stream_reader

Overview:
- Read-side initiator for the 128-word input SRAM port (33-bit words: 32 data + 1 spare) that feeds the systolic array.
- On a start command it issues sequential reads from a base address, captures each returned word, and presents it on a valid/ready stream toward the array edge.
- A small credit-controlled buffer absorbs downstream backpressure, so no read is ever issued without space to land its data.

Parameters:
- DATA_WIDTH, 33, SRAM word width; bit 32 is the spare bit.
- ADDR_WIDTH, 8, SRAM address width.
- DEPTH, 128, number of valid words; addresses wrap modulo DEPTH.
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥2).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; sampled only when busy=0.
- base_addr  in  7  first word address, sampled with start.
- len  in  8  word count, 0..128, sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the transfer completes.
- sram_csb0  out  1  active-low chip select, registered.
- sram_web0  out  1  write enable; constant 1 (read only).
- sram_spare_wen0  out  1  constant 0.
- sram_addr0  out  ADDR_WIDTH  read address, registered; bit 7 always 0.
- sram_din0  out  DATA_WIDTH  constant 0.
- sram_dout0  in  DATA_WIDTH  SRAM read data.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  32  sram_dout0[31:0] of the word.
- out_spare  out  1  sram_dout0[32] of the word.
- out_last  out  1  high with the final word of the transfer.

Behaviour:
- Reset (async, rst_n=0) forces: sram_csb0=1, sram_addr0=0, busy=0, done=0, out_valid=0, out_last=0. The buffer, counters and in-flight tracking are cleared. Any data still returning from the SRAM is discarded.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, start=1, len>0: latch base_addr and len, go to RUN. busy=1 from the next cycle.
  - IDLE, start=1, len=0: no SRAM access, stay in IDLE, done=1 the next cycle, busy stays 0.
  - RUN to DRAIN: after the last read is issued.
  - DRAIN to IDLE: on the handshake of the out_last word. done=1 in that same cycle; busy=0 from the next cycle.
  - start while busy=1 is ignored.
- Read issue: in RUN, a read is issued in a cycle when remaining>0 and (buffer occupancy + in-flight reads) < FIFO_DEPTH. Occupancy counts the pop of the current cycle.
  - An issued read drives sram_csb0=0 and sram_addr0={1'b0, (base+i) mod 128} for exactly that cycle; otherwise sram_csb0=1.
- Latency:
  - The read driven in cycle k is captured by the SRAM at edge k+1.
  - The controller samples sram_dout0 at edge k+2, before the SRAM's hold-time X, and pushes it into the buffer.
  - out_valid rises after edge k+2. Start-to-first-out_valid is 3 cycles.
- Throughput: with out_ready held high, one word per cycle.
- Stream rules:
  - out_data, out_spare and out_last are stable while out_valid=1 and out_ready=0.
  - A pop happens only when out_valid&&out_ready.
  - Words come out in address order.
  - out_last is asserted on the word with index len-1 only.
- Wrap: the address increments modulo 128. base 127 + 1 gives 0.
- Simultaneous buffer push and pop in the same cycle keeps occupancy unchanged. The buffer never overflows, by the credit rule.
- Reset mid-transfer: the block returns to IDLE with no done pulse. The next start runs normally.

Test Plan:
- Basic: base=0, len=4, out_ready=1, SRAM preloaded mem[i]=i.
  - Reads on addr 0,1,2,3 in consecutive cycles.
  - out_valid from start+3 for 4 back-to-back cycles, data 0..3, out_last on data 3.
  - done in the same cycle as that handshake.
- Wrap: base=126, len=4 -> addr sequence 126,127,0,1, and out_data matches those words.
- Backpressure: len=10 with out_ready=0.
  - Exactly 4 reads are issued, then sram_csb0 stays 1 and out_valid stays high with word 0.
  - Release out_ready: all 10 words arrive in order, no duplicates or loss.
- Edge commands:
  - len=0 -> done pulse 1 cycle later, sram_csb0 never 0.
  - start pulsed during a transfer -> ignored, original sequence unaffected.
  - len=128 -> all 128 addresses read once.
- Spare/reset:
  - Word with bit32=1 -> out_spare=1.
  - rst_n low mid-transfer -> all outputs at reset values immediately. A later transfer (base=5, len=2) completes correctly.
